// File: rtl/store_commit_if.sv
// Handshake bundle between store_commit and its SAQ / store-data queue / ROB / data-memory neighbours.
// slave is the committer's view; master is the environment's view.
interface store_commit_if #(
   parameter int WIDTH_TAG   = 5,
   parameter int WIDTH_ADDR  = 32,
   parameter int WIDTH_DATA  = 32,
   parameter int WIDTH       = 4,
   parameter int WIDTH_ENTRY = 4 + WIDTH_ADDR + WIDTH_TAG
);
   logic [WIDTH_ENTRY-1:0]  i_entry;
   logic                    i_empty;
   logic [WIDTH_DATA-1:0]   i_data;
   logic [WIDTH_DATA/8-1:0] i_be;
   logic                    i_commit;
   logic                    o_re;
   logic                    o_mem_req;
   logic [WIDTH_ADDR-1:0]   o_mem_addr;
   logic [WIDTH_DATA-1:0]   o_mem_data;
   logic [WIDTH_DATA/8-1:0] o_mem_be;
   logic                    i_mem_ack;
   logic                    o_done;
   logic [WIDTH_TAG-1:0]    o_done_tag;
   logic [WIDTH:0]          o_pending;
   logic                    o_busy;

   modport slave (
      input  i_entry, i_empty, i_data, i_be, i_commit, i_mem_ack,
      output o_re, o_mem_req, o_mem_addr, o_mem_data, o_mem_be,
             o_done, o_done_tag, o_pending, o_busy
   );

   modport master (
      output i_entry, i_empty, i_data, i_be, i_commit, i_mem_ack,
      input  o_re, o_mem_req, o_mem_addr, o_mem_data, o_mem_be,
             o_done, o_done_tag, o_pending, o_busy
   );
endinterface

// File: rtl/store_commit.sv
// Drains the store address queue in program order, writing each retired store to data memory
// with a single-beat req/ack and dequeuing squashed entries without a memory access.
//
// state | meaning
// IDLE  | examining SAQ head; issue write, skip squashed entry, or stall
// REQ   | write request held until ack
// POP   | one-cycle dequeue pulse to SAQ and store data queue
module store_commit #(
   parameter int WIDTH_TAG   = 5,
   parameter int WIDTH_ADDR  = 32,
   parameter int WIDTH_DATA  = 32,
   parameter int WIDTH       = 4,
   parameter int WIDTH_ENTRY = 4 + WIDTH_ADDR + WIDTH_TAG
) (
   input  logic           i_clk,
   input  logic           i_rst,
   store_commit_if.slave  bus
);
   localparam int WIDTH_BE = WIDTH_DATA / 8;
   localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, REQ, POP} state_t;

   state_t                state_q;
   logic [WIDTH:0]        cnt_q, cnt_d;
   logic                  re_q, mem_req_q, done_q;
   logic [WIDTH_ADDR-1:0] addr_q;
   logic [WIDTH_DATA-1:0] data_q;
   logic [WIDTH_BE-1:0]   be_q;
   logic [WIDTH_TAG-1:0]  tag_q;

   logic                  head_a, head_val, head_v, head_d;
   logic [WIDTH_ADDR-1:0] head_addr;
   logic [WIDTH_TAG-1:0]  head_tag;
   logic                  eligible, ack_taken;

   assign head_a    = bus.i_entry[WIDTH_ENTRY-1];
   assign head_val  = bus.i_entry[WIDTH_ENTRY-2];
   assign head_addr = bus.i_entry[WIDTH_ADDR+WIDTH_TAG+1:WIDTH_TAG+2];
   assign head_v    = bus.i_entry[WIDTH_TAG+1];
   assign head_d    = bus.i_entry[WIDTH_TAG];
   assign head_tag  = bus.i_entry[WIDTH_TAG-1:0];

   assign eligible  = !bus.i_empty && head_a;
   assign ack_taken = (state_q == REQ) && bus.i_mem_ack;

   // A commit and an ack in the same cycle cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.i_commit && !ack_taken)
         cnt_d = cnt_q + CNT_ONE;
      else if (!bus.i_commit && ack_taken)
         cnt_d = cnt_q - CNT_ONE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         re_q      <= 1'b0;
         mem_req_q <= 1'b0;
         done_q    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         be_q      <= '0;
         tag_q     <= '0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            IDLE: begin
               re_q   <= 1'b0;
               done_q <= 1'b0;
               if (eligible && !head_val) begin
                  re_q    <= 1'b1;
                  state_q <= POP;
               end else if (eligible && head_val && head_v && head_d && (cnt_q != '0)) begin
                  addr_q    <= head_addr;
                  data_q    <= bus.i_data;
                  be_q      <= bus.i_be;
                  tag_q     <= head_tag;
                  mem_req_q <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               if (bus.i_mem_ack) begin
                  mem_req_q <= 1'b0;
                  done_q    <= 1'b1;
                  re_q      <= 1'b1;
                  state_q   <= POP;
               end
            end
            POP: begin
               re_q    <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_re       = re_q;
   assign bus.o_mem_req  = mem_req_q;
   assign bus.o_mem_addr = addr_q;
   assign bus.o_mem_data = data_q;
   assign bus.o_mem_be   = be_q;
   assign bus.o_done     = done_q;
   assign bus.o_done_tag = tag_q;
   assign bus.o_pending  = cnt_q;
   assign bus.o_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_store_commit.sv
// Bench for store_commit: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the store queue drain.
module tb_store_commit;
   localparam int WT   = 5;
   localparam int WA   = 32;
   localparam int WD   = 32;
   localparam int WB   = WD / 8;
   localparam int W    = 4;
   localparam int WE   = 4 + WA + WT;
   localparam int SIZE = 1 << W;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   store_commit_if #(.WIDTH_TAG(WT), .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .WIDTH(W)) bus ();

   store_commit #(.WIDTH_TAG(WT), .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .WIDTH(W)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   typedef struct {
      bit          a, val, v, d;
      logic [WA-1:0] addr;
      logic [WD-1:0] data;
      logic [WB-1:0] be;
      logic [WT-1:0] tag;
   } st_t;

   st_t saq[$];
   int  vectors = 0;
   int  miscompares = 0;
   bit  cmp_en = 0;

   // Model: at most one write in flight; after it (or a squashed head) comes one dequeue cycle.
   bit            m_inflight, m_popping, e_re, e_done, m_ack;
   int            m_pending, m_old;
   logic [WA-1:0] e_addr;
   logic [WD-1:0] e_data;
   logic [WB-1:0] e_be;
   logic [WT-1:0] e_tag;
   st_t           m_h;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic st_t mkst(bit a, bit val, bit v, bit d, logic [WA-1:0] addr,
                                logic [WD-1:0] data, logic [WB-1:0] be, logic [WT-1:0] tag);
      st_t s;
      s.a = a; s.val = val; s.v = v; s.d = d;
      s.addr = addr; s.data = data; s.be = be; s.tag = tag;
      return s;
   endfunction

   always @(posedge i_clk) begin
      if (i_rst) begin
         m_inflight = 0; m_popping = 0; e_re = 0; e_done = 0; m_pending = 0;
         e_addr = '0; e_data = '0; e_be = '0; e_tag = '0;
      end else begin
         m_old     = m_pending;
         m_ack     = m_inflight && (bus.i_mem_ack === 1'b1);
         m_pending = m_pending + (bus.i_commit ? 1 : 0) - (m_ack ? 1 : 0);
         if (m_pending > SIZE || m_pending < 0) begin
            miscompares++;
            $display("FAIL pending_bound: count %0d, required 0..%0d", m_pending, SIZE);
         end
         e_re   = 0;
         e_done = 0;
         if (m_popping) begin
            m_popping = 0;
         end else if (m_inflight) begin
            if (m_ack) begin
               m_inflight = 0; e_done = 1; e_re = 1; m_popping = 1;
            end
         end else if (saq.size() > 0 && saq[0].a) begin
            m_h = saq[0];
            if (!m_h.val) begin
               e_re = 1; m_popping = 1;
            end else if (m_h.v && m_h.d && m_old > 0) begin
               m_inflight = 1;
               e_addr = m_h.addr; e_data = m_h.data; e_be = m_h.be; e_tag = m_h.tag;
            end
         end
      end
   end

   always @(negedge i_clk) begin
      if (cmp_en) begin
         check("mem_req",  bus.o_mem_req,  m_inflight);
         check("re",       bus.o_re,       e_re);
         check("done",     bus.o_done,     e_done);
         check("busy",     bus.o_busy,     m_inflight || m_popping);
         check("pending",  bus.o_pending,  m_pending);
         check("mem_addr", bus.o_mem_addr, e_addr);
         check("mem_data", bus.o_mem_data, e_data);
         check("mem_be",   bus.o_mem_be,   e_be);
         check("done_tag", bus.o_done_tag, e_tag);
      end
   end

   task automatic drive_head();
      logic [63:0] r;
      if (saq.size() == 0) begin
         r = {$urandom, $urandom};
         bus.i_empty = 1'b1;
         bus.i_entry = r[WE-1:0];
         bus.i_data  = $urandom;
         bus.i_be    = r[WB-1:0];
      end else begin
         bus.i_empty = 1'b0;
         bus.i_entry = {saq[0].a, saq[0].val, saq[0].addr, saq[0].v, saq[0].d, saq[0].tag};
         bus.i_data  = saq[0].data;
         bus.i_be    = saq[0].be;
      end
   endtask

   // Dequeue takes effect at the end of the o_re cycle; the head is ignored then, so pop early.
   task automatic tick();
      @(negedge i_clk);
      if (bus.o_re === 1'b1 && saq.size() > 0) saq.delete(0);
      drive_head();
   endtask

   task automatic do_reset();
      i_rst = 1'b1; bus.i_commit = 1'b1; bus.i_mem_ack = 1'b1;
      saq.delete();
      repeat (2) tick();
      i_rst = 1'b0; bus.i_commit = 1'b0; bus.i_mem_ack = 1'b0;
   endtask

   task automatic wait_req(input int max);
      int n;
      n = 0;
      while (bus.o_mem_req !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      check("req_timeout", bus.o_mem_req, 1);
   endtask

   task automatic ack_once();
      bus.i_mem_ack = 1'b1;
      tick();
      bus.i_mem_ack = 1'b0;
   endtask

   initial begin
      int re_n, req_n, gap_bad, last;
      st_t h;
      bus.i_entry = '0; bus.i_empty = 1'b1; bus.i_data = '0; bus.i_be = '0;
      bus.i_commit = 1'b0; bus.i_mem_ack = 1'b0;

      // Reset with commit and ack held high
      do_reset();
      cmp_en = 1;
      check("rst_pending", bus.o_pending, 0);
      check("rst_re", bus.o_re, 0);
      check("rst_req", bus.o_mem_req, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_busy", bus.o_busy, 0);

      // Single store
      saq.push_back(mkst(1, 1, 1, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 5'd3));
      drive_head();
      bus.i_commit = 1'b1;
      tick();
      bus.i_commit = 1'b0;
      check("single_pend1", bus.o_pending, 1);
      check("single_noreq_yet", bus.o_mem_req, 0);
      tick();
      check("single_req", bus.o_mem_req, 1);
      check("single_addr", bus.o_mem_addr, 32'h1000);
      check("single_data", bus.o_mem_data, 32'hDEADBEEF);
      check("single_be", bus.o_mem_be, 4'hF);
      tick();
      check("single_req_hold", bus.o_mem_req, 1);
      check("single_addr_hold", bus.o_mem_addr, 32'h1000);
      ack_once();
      check("single_done", bus.o_done, 1);
      check("single_tag", bus.o_done_tag, 3);
      check("single_re", bus.o_re, 1);
      check("single_req_drop", bus.o_mem_req, 0);
      check("single_pend0", bus.o_pending, 0);
      tick();
      check("single_re_once", bus.o_re, 0);
      check("single_idle", bus.o_busy, 0);

      // Ready head, not retired
      do_reset();
      saq.push_back(mkst(1, 1, 1, 1, 32'h2000, 32'h12345678, 4'h3, 5'd9));
      drive_head();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("noret_req", bus.o_mem_req, 0);
      end
      bus.i_commit = 1'b1;
      tick();
      bus.i_commit = 1'b0;
      check("noret_req_t1", bus.o_mem_req, 0);
      tick();
      check("noret_req_t2", bus.o_mem_req, 1);
      check("noret_addr", bus.o_mem_addr, 32'h2000);
      ack_once();
      tick();

      // Squashed run then a valid store
      do_reset();
      for (int i = 0; i < 3; i++)
         saq.push_back(mkst(1, 0, 1, 1, $urandom, $urandom, 4'h1, 5'(i)));
      saq.push_back(mkst(1, 1, 1, 1, 32'h3000, 32'hCAFEF00D, 4'hC, 5'd7));
      drive_head();
      bus.i_commit = 1'b1;
      tick();
      bus.i_commit = 1'b0;
      re_n = 0; req_n = 0; gap_bad = 0; last = -10;
      for (int i = 1; i <= 6; i++) begin
         if (i > 1) tick();
         if (bus.o_re === 1'b1) begin
            if (re_n > 0 && i - last != 2) gap_bad++;
            last = i;
            re_n++;
         end
         if (bus.o_mem_req === 1'b1) req_n++;
      end
      check("squash_re_count", re_n, 3);
      check("squash_no_req", req_n, 0);
      check("squash_gap", gap_bad, 0);
      wait_req(4);
      check("squash_addr", bus.o_mem_addr, 32'h3000);
      ack_once();
      check("squash_done_tag", bus.o_done_tag, 7);
      tick();

      // Commit coinciding with ack
      do_reset();
      saq.push_back(mkst(1, 1, 1, 1, 32'h4000, 32'h11111111, 4'hF, 5'd1));
      saq.push_back(mkst(1, 1, 1, 1, 32'h4004, 32'h22222222, 4'hF, 5'd2));
      drive_head();
      bus.i_commit = 1'b1;
      tick();
      tick();
      bus.i_commit = 1'b0;
      check("simul_pend2", bus.o_pending, 2);
      check("simul_req", bus.o_mem_req, 1);
      bus.i_mem_ack = 1'b1; bus.i_commit = 1'b1;
      tick();
      bus.i_mem_ack = 1'b0; bus.i_commit = 1'b0;
      check("simul_pend_hold", bus.o_pending, 2);
      check("simul_done_tag", bus.o_done_tag, 1);
      tick();
      check("simul_gap", bus.o_mem_req, 0);
      tick();
      check("simul_req2", bus.o_mem_req, 1);
      check("simul_addr2", bus.o_mem_addr, 32'h4004);
      ack_once();
      check("simul_pend1", bus.o_pending, 1);
      check("simul_done_tag2", bus.o_done_tag, 2);
      tick();

      // Reset while a request is outstanding
      do_reset();
      saq.push_back(mkst(1, 1, 1, 1, 32'h5000, 32'h55AA55AA, 4'h5, 5'd11));
      drive_head();
      bus.i_commit = 1'b1;
      tick();
      bus.i_commit = 1'b0;
      wait_req(4);
      i_rst = 1'b1;
      saq.delete();
      tick();
      i_rst = 1'b0;
      check("midrst_req", bus.o_mem_req, 0);
      check("midrst_re", bus.o_re, 0);
      check("midrst_done", bus.o_done, 0);
      check("midrst_pending", bus.o_pending, 0);
      check("midrst_addr", bus.o_mem_addr, 0);
      tick();
      check("midrst_re_after", bus.o_re, 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         if ($urandom_range(599) == 0) begin
            i_rst = 1'b1;
            saq.delete();
         end else begin
            i_rst = 1'b0;
         end
         if (saq.size() < 8 && $urandom_range(2) == 0)
            saq.push_back(mkst($urandom_range(3) != 0, $urandom_range(4) != 0,
                               $urandom_range(3) != 0, $urandom_range(3) != 0,
                               $urandom, $urandom, 4'($urandom), 5'($urandom)));
         if (saq.size() > 0 && $urandom_range(2) == 0) begin
            h = saq[0];
            case ($urandom_range(2))
               0: h.a = 1;
               1: h.v = 1;
               default: h.d = 1;
            endcase
            saq[0] = h;
         end
         drive_head();
         bus.i_commit  = (m_pending < SIZE) && ($urandom_range(2) == 0);
         bus.i_mem_ack = (bus.o_mem_req === 1'b1) ? ($urandom_range(2) == 0)
                                                  : ($urandom_range(7) == 0);
      end
      i_rst = 1'b0; bus.i_commit = 1'b0; bus.i_mem_ack = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
